// File: rtl/digit_feature_extract.sv
// digit_feature_extract
// Consumes the projection stage results: reads the column/row border RAMs to
// latch each digit's bounding box, scans the next frame's monochrome stream
// counting foreground crossings on three probe lines per digit, then emits one
// 6-bit feature word per digit.
//
// Ports
//   clk, rst_n                  pixel clock, async active-low reset
//   frame_vsync                 falling edge = frame boundary
//   frame_de, monoc, xpos, ypos pixel stream (monoc 0 = foreground)
//   project_done_flag           rising edge starts a run (num_col/num_row valid)
//   col/row_border_addr_rd      border RAM read addresses (1-cycle read latency)
//   col/row_border_data_rd      border RAM read data
//   feature_valid/idx/feature   one strobe per digit, {v, h1, h2} 2-bit counts
//   busy                        high whenever not idle
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for project_done_flag rising edge with a non-empty result
// LOAD   | reading row borders then column borders, one address per cycle
// WAIT   | bounding boxes ready, waiting for the next frame start
// SCAN   | counting probe-line crossings over one frame
// EMIT   | one feature word per cycle, digits 0..ncol-1
module digit_feature_extract #(
    parameter int NUM_COL = 4,
    parameter int H_PIXEL = 480,
    parameter int V_PIXEL = 272,
    parameter int DEPBIT  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_vsync,
    input  logic              frame_de,
    input  logic              monoc,
    input  logic [10:0]       xpos,
    input  logic [10:0]       ypos,
    input  logic              project_done_flag,
    input  logic [3:0]        num_col,
    input  logic [3:0]        num_row,
    output logic [DEPBIT-1:0] col_border_addr_rd,
    input  logic [DEPBIT-1:0] col_border_data_rd,
    output logic [DEPBIT-1:0] row_border_addr_rd,
    input  logic [DEPBIT-1:0] row_border_data_rd,
    output logic              feature_valid,
    output logic [3:0]        feature_idx,
    output logic [5:0]        feature,
    output logic              busy
);

    localparam int IW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
    localparam logic [10:0] H_LIM = 11'(H_PIXEL);
    localparam logic [10:0] V_LIM = 11'(V_PIXEL);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_SCAN, S_EMIT} state_t;

    state_t            state_q, state_d;
    logic              pdf_q, vs_q;
    logic [3:0]        ncol_q, ncol_in, ecnt;
    logic [DEPBIT-1:0] lcnt, load_end;
    logic [10:0]       top_q, bot_q, h, y1, y2;
    logic [10:0]       left_q  [NUM_COL];
    logic [10:0]       right_q [NUM_COL];
    logic [10:0]       mid     [NUM_COL];
    logic [1:0]        h1_cnt  [NUM_COL];
    logic [1:0]        h2_cnt  [NUM_COL];
    logic [1:0]        v_cnt   [NUM_COL];
    logic              vprev   [NUM_COL];
    logic              prev_fg, fg, pdf_rise, vs_fall, go_load;
    logic              load_last, emit_last, pix_ok;

    assign fg        = ~monoc;
    assign pdf_rise  = project_done_flag & ~pdf_q;
    assign vs_fall   = vs_q & ~frame_vsync;
    assign go_load   = pdf_rise && (num_col != 4'd0) && (num_row != 4'd0);
    assign ncol_in   = (num_col > 4'(NUM_COL)) ? 4'(NUM_COL) : num_col;
    // Last LOAD cycle captures the final right edge: index 2*ncol+2.
    assign load_end  = DEPBIT'({ncol_q, 1'b0}) + DEPBIT'(2);
    assign load_last = (state_q == S_LOAD) && (lcnt == load_end);
    assign emit_last = (ecnt == ncol_q - 4'd1);
    // A pixel coinciding with the closing vsync fall is dropped.
    assign pix_ok    = (state_q == S_SCAN) && frame_de && !vs_fall &&
                       (xpos < H_LIM) && (ypos < V_LIM);

    // Probe geometry is derived straight from the latched borders.
    assign h  = bot_q - top_q;
    assign y1 = top_q + (h >> 2) + (h >> 3);
    assign y2 = top_q + (h >> 1) + (h >> 3);

    always_comb begin
        for (int k = 0; k < NUM_COL; k++) begin
            mid[k] = (left_q[k] + right_q[k]) >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go_load)   state_d = S_LOAD;
            S_LOAD:  if (load_last) state_d = S_WAIT;
            S_WAIT:  if (vs_fall)   state_d = S_SCAN;
            S_SCAN:  if (vs_fall)   state_d = S_EMIT;
            S_EMIT:  if (emit_last) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy               = (state_q != S_IDLE);
        feature_valid      = 1'b0;
        feature_idx        = 4'd0;
        feature            = 6'd0;
        row_border_addr_rd = '0;
        col_border_addr_rd = '0;
        if (state_q == S_LOAD) begin
            if (lcnt < DEPBIT'(2))
                row_border_addr_rd = lcnt + DEPBIT'(1);
            else if (lcnt < load_end)
                col_border_addr_rd = lcnt - DEPBIT'(1);
        end
        if (state_q == S_EMIT) begin
            feature_valid = 1'b1;
            feature_idx   = ecnt;
            feature       = {v_cnt[ecnt[IW-1:0]], h1_cnt[ecnt[IW-1:0]], h2_cnt[ecnt[IW-1:0]]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pdf_q   <= 1'b0;
            vs_q    <= 1'b0;
            ncol_q  <= 4'd0;
            lcnt    <= '0;
            ecnt    <= 4'd0;
            top_q   <= 11'd0;
            bot_q   <= 11'd0;
            prev_fg <= 1'b0;
            for (int k = 0; k < NUM_COL; k++) begin
                left_q[k]  <= 11'd0;
                right_q[k] <= 11'd0;
                h1_cnt[k]  <= 2'd0;
                h2_cnt[k]  <= 2'd0;
                v_cnt[k]   <= 2'd0;
                vprev[k]   <= 1'b0;
            end
        end else begin
            pdf_q <= project_done_flag;
            vs_q  <= frame_vsync;
            if (state_q == S_IDLE && go_load) ncol_q <= ncol_in;
            lcnt <= (state_q == S_LOAD) ? lcnt + DEPBIT'(1) : '0;
            ecnt <= (state_q == S_EMIT) ? ecnt + 4'd1 : 4'd0;

            // Data for the address issued at lcnt-1 is present at lcnt.
            if (state_q == S_LOAD) begin
                if (lcnt == DEPBIT'(1)) top_q <= 11'(row_border_data_rd);
                if (lcnt == DEPBIT'(2)) bot_q <= 11'(row_border_data_rd);
                for (int k = 0; k < NUM_COL; k++) begin
                    if (lcnt == DEPBIT'(3 + 2 * k)) left_q[k]  <= 11'(col_border_data_rd);
                    if (lcnt == DEPBIT'(4 + 2 * k)) right_q[k] <= 11'(col_border_data_rd);
                end
            end

            if (load_last) begin
                for (int k = 0; k < NUM_COL; k++) begin
                    h1_cnt[k] <= 2'd0;
                    h2_cnt[k] <= 2'd0;
                    v_cnt[k]  <= 2'd0;
                end
            end

            if (state_q == S_WAIT && vs_fall) begin
                prev_fg <= 1'b0;
                for (int k = 0; k < NUM_COL; k++) vprev[k] <= 1'b0;
            end

            if (pix_ok) begin
                prev_fg <= fg;
                for (int k = 0; k < NUM_COL; k++) begin
                    // Previous pixel treated as background at the left border
                    // so a stroke touching the border still counts.
                    if (xpos >= left_q[k] && xpos <= right_q[k] && fg &&
                        !(prev_fg && xpos != left_q[k])) begin
                        if (ypos == y1 && h1_cnt[k] != 2'd3) h1_cnt[k] <= h1_cnt[k] + 2'd1;
                        if (ypos == y2 && h2_cnt[k] != 2'd3) h2_cnt[k] <= h2_cnt[k] + 2'd1;
                    end
                    if (xpos == mid[k] && ypos >= top_q && ypos <= bot_q) begin
                        if (fg && !vprev[k] && v_cnt[k] != 2'd3) v_cnt[k] <= v_cnt[k] + 2'd1;
                        vprev[k] <= fg;
                    end
                end
            end
        end
    end

endmodule
